// File: rtl/adc_frame_packer.sv
// Decimating sample FIFO that emits framed packets to the UART:
// header, sequence number, FRAME_LEN samples, XOR checksum.
module adc_frame_packer #(
    parameter int DATA_W = 8,
    parameter int DECIM = 4,
    parameter int FRAME_LEN = 8,
    parameter int FIFO_DEPTH = 16,
    parameter logic [DATA_W-1:0] HEADER = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              overflow,
    output logic [4:0]        fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_V = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] FLEN_V = LW'(FRAME_LEN);
    localparam logic [LW-1:0] FLEN_M1 = LW'(FRAME_LEN - 1);
    localparam logic [7:0] DECIM_M1 = 8'(DECIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        DATA,
        CSUM
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wptr, rptr, rptr_nx;
    logic [LW-1:0]     level;
    logic [7:0]        dcnt;
    logic              ovf;

    logic [DATA_W-1:0] data_q, data_n;
    logic              valid_q, valid_n;
    logic [DATA_W-1:0] csum_q, csum_n;
    logic [DATA_W-1:0] seq_q, seq_n;
    logic [LW-1:0]     cnt_q, cnt_n;

    logic xfer, pop, kept, push;

    assign xfer = valid_q && tx_ready;
    assign pop = (state == DATA) && xfer;
    assign kept = enable && sample_valid && (dcnt == 8'd0);
    // A full FIFO still accepts a sample when a pop frees a slot this cycle.
    assign push = kept && ((level < DEPTH_V) || pop);
    assign rptr_nx = rptr + AW'(1);

    assign tx_data = data_q;
    assign tx_valid = valid_q;
    assign overflow = ovf;
    assign fifo_level = 5'(level);

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            data_q <= '0;
            valid_q <= 1'b0;
            csum_q <= '0;
            seq_q <= '0;
            cnt_q <= '0;
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            dcnt <= '0;
            ovf <= 1'b0;
        end else begin
            state <= state_n;
            data_q <= data_n;
            valid_q <= valid_n;
            csum_q <= csum_n;
            seq_q <= seq_n;
            cnt_q <= cnt_n;
            if (!enable) dcnt <= '0;
            else if (sample_valid)
                dcnt <= (dcnt == DECIM_M1) ? 8'd0 : dcnt + 8'd1;
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr_nx;
            if (push && !pop) level <= level + LW'(1);
            else if (!push && pop) level <= level - LW'(1);
            if (kept && !push) ovf <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        data_n = data_q;
        valid_n = valid_q;
        csum_n = csum_q;
        seq_n = seq_q;
        cnt_n = cnt_q;
        unique case (state)
            IDLE: begin
                if (level >= FLEN_V) begin
                    state_n = HDR;
                    valid_n = 1'b1;
                    data_n = HEADER;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_n = SEQ;
                    data_n = seq_q;
                    csum_n = seq_q;
                end
            end
            SEQ: begin
                if (xfer) begin
                    state_n = DATA;
                    cnt_n = '0;
                    data_n = mem[rptr];
                end
            end
            DATA: begin
                // The next head is already written: enough entries remain.
                if (xfer) begin
                    csum_n = csum_q ^ data_q;
                    cnt_n = cnt_q + LW'(1);
                    if (cnt_q == FLEN_M1) begin
                        state_n = CSUM;
                        data_n = csum_q ^ data_q;
                    end else begin
                        data_n = mem[rptr_nx];
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    data_n = '0;
                    seq_n = seq_q + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
